tpu_sequencer: RTL

Parametrised instruction sequencer for the TPU datapath. It accepts a program from the host over a valid/ready byte stream into a local instruction memory. On `start` it fetches and executes the program, driving the one-hot control strobes that the unified buffer, weight FIFO and systolic array consume. It adds three capabilities over the previous controller: configurable depth, compute length and address width; a backpressured load port; and an optional hardware loop.

---
 rtl/tpu_sequencer_if.sv | 48 ++++
 rtl/tpu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer_if.sv
// tpu_sequencer_if: host program stream, run control and datapath strobes
// of the TPU instruction sequencer.
interface tpu_sequencer_if #(
  parameter int ADDR_W = 13
);
  logic              prog_valid;
  logic [7:0]        prog_data;
  logic              prog_ready;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] base_address;
  logic              load_weight;
  logic              load_input;
  logic              valid;
  logic              store;
  logic              ext;

  modport master (
    output prog_valid,
    output prog_data,
    output start,
    input  prog_ready,
    input  busy,
    input  done,
    input  base_address,
    input  load_weight,
    input  load_input,
    input  valid,
    input  store,
    input  ext
  );

  modport slave (
    input  prog_valid,
    input  prog_data,
    input  start,
    output prog_ready,
    output busy,
    output done,
    output base_address,
    output load_weight,
    output load_input,
    output valid,
    output store,
    output ext
  );
endinterface

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: loads a byte program from the host, then fetches and runs it,
// driving datapath strobes. Define SEQ_LOOP_EN to build LOOP (else a NOP).
module tpu_sequencer #(
  parameter int IMEM_DEPTH     = 16,
  parameter int ADDR_W         = 13,
  parameter int COMPUTE_CYCLES = 5
) (
  input logic            clk,
  input logic            reset_n,
  tpu_sequencer_if.slave bus
);

  localparam int PC_W  = $clog2(IMEM_DEPTH);
  localparam int WP_W  = PC_W + 1;
  localparam int CNT_W =
    (COMPUTE_CYCLES > 31) ? $clog2(COMPUTE_CYCLES + 1) : 5;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_DEPTH - 1);
  localparam logic [WP_W-1:0] WP_MAX  = WP_W'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_HALT  = 3'd0,
    OP_ADDR  = 3'd1,
    OP_LDW   = 3'd2,
    OP_LDI   = 3'd3,
    OP_COMP  = 3'd4,
    OP_STORE = 3'd5,
    OP_LOOP  = 3'd6,
    OP_EXT   = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WP_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        imem_q [IMEM_DEPTH];

`ifdef SEQ_LOOP_EN
  logic [4:0] lc_q, lc_d;
  logic       la_q, la_d;
`endif

  op_e              op;
  logic [4:0]       k;
  logic [CNT_W-1:0] comp_len;
  logic             exec;
  logic             wr_en;
  logic             hold;
  logic             jump;
  logic             fin;

  assign op   = op_e'(ir_q[7:5]);
  assign k    = ir_q[4:0];
  assign exec = (state_q == S_EXEC);

  // operand 0 selects the default compute length
  assign comp_len = (k != 5'd0) ? CNT_W'(k)
                                : CNT_W'(COMPUTE_CYCLES);

  assign bus.prog_ready = (state_q == S_IDLE) &&
                          (wr_ptr_q < WP_MAX);

  // start wins over a byte offered in the same cycle
  assign wr_en = (state_q == S_IDLE) && bus.prog_valid &&
                 bus.prog_ready && !bus.start;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    ir_d     = ir_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
`ifdef SEQ_LOOP_EN
    lc_d     = lc_q;
    la_d     = la_q;
`endif
    hold     = 1'b0;
    jump     = 1'b0;
    fin      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          wr_ptr_d = '0;
        end else if (wr_en) begin
          wr_ptr_d = wr_ptr_q + WP_W'(1);
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op)
          OP_HALT: fin = 1'b1;
          OP_ADDR: base_d = ADDR_W'(k);
          OP_COMP: begin
            if (cnt_q + CNT_W'(1) != comp_len) begin
              hold  = 1'b1;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef SEQ_LOOP_EN
          OP_LOOP: begin
            if (!la_q) begin
              if (k != 5'd0) begin
                lc_d = k;
                la_d = 1'b1;
                jump = 1'b1;
              end
            end else if (lc_q == 5'd1) begin
              la_d = 1'b0;
            end else begin
              lc_d = lc_q - 5'd1;
              jump = 1'b1;
            end
          end
`endif
          default: ;
        endcase
        if (hold) begin
          state_d = S_EXEC;
        end else if (jump) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end else if (fin || (pc_q == LAST_PC)) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      ir_q     <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      ir_q     <= ir_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        imem_q[i] <= '0;
      end
    end else if (wr_en) begin
      imem_q[wr_ptr_q[PC_W-1:0]] <= bus.prog_data;
    end
  end

`ifdef SEQ_LOOP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lc_q <= '0;
      la_q <= 1'b0;
    end else begin
      lc_q <= lc_d;
      la_q <= la_d;
    end
  end
`endif

  assign bus.load_weight  = exec && (op == OP_LDW);
  assign bus.load_input   = exec && (op == OP_LDI);
  assign bus.valid        = exec && (op == OP_COMP);
  assign bus.store        = exec && (op == OP_STORE);
  assign bus.ext          = exec && (op == OP_EXT);
  assign bus.busy         = (state_q == S_FETCH) || exec;
  assign bus.done         = (state_q == S_DONE);
  assign bus.base_address = base_q;

endmodule
